// File: rtl/slv_guard_rst_pkg.sv
// Shared definitions for the subordinate-guard recovery sequencer.
// Holds the recovery state encoding and the default counter widths.
package slv_guard_rst_pkg;

    localparam int unsigned DefCntWidth    = 10;
    localparam int unsigned DefRstCntWidth = 8;

    typedef enum logic [2:0] {
        RST_IDLE     = 3'd0,
        RST_ISOLATE  = 3'd1,
        RST_ASSERT   = 3'd2,
        RST_SETTLE   = 3'd3,
        RST_CLEAR    = 3'd4,
        RST_WAIT_ACK = 3'd5
    } rst_state_e;

endpackage

// File: rtl/slv_guard_rst_timer.sv
// Shared phase timer: counts up every cycle unless cleared, and flags when
// the count has reached the limit supplied for the current phase.
module slv_guard_rst_timer
    import slv_guard_rst_pkg::*;
#(
    parameter int unsigned CntWidth = DefCntWidth
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic [CntWidth-1:0] limit_i,
    output logic                expired_o
);

    logic [CntWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = clear_i ? '0 : count_q + CntWidth'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == limit_i);

endmodule

// File: rtl/slv_guard_rst_ctrl.sv
// Recovery sequencer: isolate the subordinate, drain, pulse its reset, settle,
// then tell the guards the reset is done. All outputs are Moore-decoded.
module slv_guard_rst_ctrl
    import slv_guard_rst_pkg::*;
#(
    parameter int unsigned CntWidth    = DefCntWidth,
    parameter int unsigned RstCntWidth = DefRstCntWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rst_req_i,
    input  logic                   quiesced_i,
    input  logic [CntWidth-1:0]    drain_budget_i,
    input  logic [CntWidth-1:0]    hold_cycles_i,
    input  logic [CntWidth-1:0]    settle_cycles_i,
    input  logic                   sw_ack_en_i,
    input  logic                   sw_ack_i,
    output logic                   isolate_o,
    output logic                   sub_rst_no,
    output logic                   rst_stat_o,
    output logic                   irq_o,
    output logic                   busy_o,
    output logic                   drain_to_o,
    output logic [RstCntWidth-1:0] rst_count_o
);

    localparam logic [2:0] StIdle    = RST_IDLE;
    localparam logic [2:0] StIsolate = RST_ISOLATE;
    localparam logic [2:0] StAssert  = RST_ASSERT;
    localparam logic [2:0] StSettle  = RST_SETTLE;
    localparam logic [2:0] StClear   = RST_CLEAR;
    localparam logic [2:0] StWaitAck = RST_WAIT_ACK;

    logic [2:0]             state_q, state_d;
    logic [CntWidth-1:0]    drain_q, hold_q, settle_q;
    logic                   ack_en_q;
    logic                   drain_to_q, drain_to_d;
    logic [RstCntWidth-1:0] cnt_q, cnt_d;
    logic                   latch_cfg;
    logic                   timer_clear;
    logic                   timer_expired;
    logic [CntWidth-1:0]    timer_limit;
    logic [CntWidth-1:0]    hold_last, settle_last;

    // A zero length still yields one cycle, so the last count index is max(n,1)-1.
    assign hold_last   = (hold_q == '0)   ? '0 : hold_q - CntWidth'(1);
    assign settle_last = (settle_q == '0) ? '0 : settle_q - CntWidth'(1);

    always_comb begin
        state_d     = state_q;
        drain_to_d  = drain_to_q;
        cnt_d       = cnt_q;
        latch_cfg   = 1'b0;
        timer_limit = '0;
        if (sw_ack_i) begin
            drain_to_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (rst_req_i) begin
                    state_d   = StIsolate;
                    latch_cfg = 1'b1;
                end
            end
            StIsolate: begin
                timer_limit = drain_q;
                if (quiesced_i) begin
                    state_d = StAssert;
                end else if (timer_expired) begin
                    state_d    = StAssert;
                    drain_to_d = 1'b1;
                end
            end
            StAssert: begin
                timer_limit = hold_last;
                if (timer_expired) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                timer_limit = settle_last;
                if (timer_expired) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                cnt_d   = (&cnt_q) ? cnt_q : cnt_q + RstCntWidth'(1);
                state_d = ack_en_q ? StWaitAck : StIdle;
            end
            StWaitAck: begin
                if (sw_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The timer only runs inside the three timed phases and restarts on every transition.
    always_comb begin
        timer_clear = (state_d != state_q) ||
                      !((state_q == StIsolate) || (state_q == StAssert) || (state_q == StSettle));
    end

    slv_guard_rst_timer #(
        .CntWidth (CntWidth)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (timer_clear),
        .limit_i   (timer_limit),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            drain_to_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            drain_to_q <= drain_to_d;
            cnt_q      <= cnt_d;
        end
    end

    // Shadow copies keep a recovery immune to config changes mid-flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drain_q  <= '0;
            hold_q   <= '0;
            settle_q <= '0;
            ack_en_q <= 1'b0;
        end else if (latch_cfg) begin
            drain_q  <= drain_budget_i;
            hold_q   <= hold_cycles_i;
            settle_q <= settle_cycles_i;
            ack_en_q <= sw_ack_en_i;
        end
    end

    assign isolate_o   = (state_q != StIdle);
    assign busy_o      = (state_q != StIdle);
    assign irq_o       = (state_q != StIdle);
    assign sub_rst_no  = (state_q != StAssert);
    assign rst_stat_o  = (state_q == StClear);
    assign drain_to_o  = drain_to_q;
    assign rst_count_o = cnt_q;

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Bench for slv_guard_rst_ctrl: directed vector table, hand-written corner
// sequences, and random recoveries checked against a per-recovery timeline model.
module tb_slv_guard_rst_ctrl;

    logic       clk_i;
    logic       rst_ni;
    logic       rst_req_i;
    logic       quiesced_i;
    logic [9:0] drain_budget_i;
    logic [9:0] hold_cycles_i;
    logic [9:0] settle_cycles_i;
    logic       sw_ack_en_i;
    logic       sw_ack_i;
    logic       isolate_o;
    logic       sub_rst_no;
    logic       rst_stat_o;
    logic       irq_o;
    logic       busy_o;
    logic       drain_to_o;
    logic [7:0] rst_count_o;

    slv_guard_rst_ctrl dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .rst_req_i       (rst_req_i),
        .quiesced_i      (quiesced_i),
        .drain_budget_i  (drain_budget_i),
        .hold_cycles_i   (hold_cycles_i),
        .settle_cycles_i (settle_cycles_i),
        .sw_ack_en_i     (sw_ack_en_i),
        .sw_ack_i        (sw_ack_i),
        .isolate_o       (isolate_o),
        .sub_rst_no      (sub_rst_no),
        .rst_stat_o      (rst_stat_o),
        .irq_o           (irq_o),
        .busy_o          (busy_o),
        .drain_to_o      (drain_to_o),
        .rst_count_o     (rst_count_o)
    );

    // Output bit order: {isolate, sub_rst_n, rst_stat, irq, busy, drain_to}
    localparam logic [5:0] O_IDLE = 6'b010000;
    localparam logic [5:0] O_ISO  = 6'b110110;
    localparam logic [5:0] O_ASRT = 6'b100110;
    localparam logic [5:0] O_CLR  = 6'b111110;

    typedef struct {
        logic       req;
        logic       quies;
        logic       ack;
        logic       ack_en;
        logic [9:0] drain;
        logic [9:0] hold;
        logic [9:0] settle;
        logic [5:0] exp_o;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl[22];
    int   n_vec = 0;
    int   n_err = 0;
    bit   drain_m = 1'b0;
    int   cnt_m = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [13:0] obs();
        return {isolate_o, sub_rst_no, rst_stat_o, irq_o, busy_o, drain_to_o, rst_count_o};
    endfunction

    function automatic vec_t mk(input logic req, input logic quies, input logic ack,
                                input logic ack_en, input int d, input int h, input int s,
                                input logic [5:0] eo, input int ec);
        vec_t v;
        v.req = req; v.quies = quies; v.ack = ack; v.ack_en = ack_en;
        v.drain = 10'(d); v.hold = 10'(h); v.settle = 10'(s);
        v.exp_o = eo; v.exp_cnt = 8'(ec);
        return v;
    endfunction

    function automatic int max1(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                     name, act[13:8], act[7:0], exp[13:8], exp[7:0]);
        end
    endtask

    task automatic tick_chk(input string name, input logic [5:0] base);
        @(posedge clk_i);
        #1;
        check(name, obs(), {base | {5'b0, drain_m}, 8'(cnt_m)});
    endtask

    task automatic bump_cnt();
        cnt_m = (cnt_m >= 255) ? 255 : cnt_m + 1;
    endtask

    task automatic scramble();
        rst_req_i       = 1'($urandom_range(0, 1));
        drain_budget_i  = 10'($urandom_range(0, 1023));
        hold_cycles_i   = 10'($urandom_range(0, 1023));
        settle_cycles_i = 10'($urandom_range(0, 1023));
        sw_ack_en_i     = 1'($urandom_range(0, 1));
        quiesced_i      = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_ack();
        sw_ack_i = ($urandom_range(0, 3) == 0);
        if (sw_ack_i) drain_m = 1'b0;
    endtask

    // Expected timeline of one recovery is built from its phase lengths.
    task automatic random_recovery();
        int budget, hold, settle, liso, wait_n;
        bit ack_en, to;
        bit qpat[8];
        budget = $urandom_range(0, 6);
        hold   = $urandom_range(0, 5);
        settle = $urandom_range(0, 5);
        ack_en = 1'($urandom_range(0, 1));
        liso   = budget + 1;
        to     = 1'b1;
        for (int k = 0; k <= budget; k++) begin
            qpat[k] = ($urandom_range(0, 2) == 0);
            if (qpat[k] && to) begin
                liso = k + 1;
                to   = 1'b0;
            end
        end
        rst_req_i = 1'b1; drain_budget_i = 10'(budget); hold_cycles_i = 10'(hold);
        settle_cycles_i = 10'(settle); sw_ack_en_i = ack_en; sw_ack_i = 1'b0;
        quiesced_i = 1'($urandom_range(0, 1));
        tick_chk("rnd_iso_entry", O_ISO);
        for (int k = 0; k < liso; k++) begin
            scramble();
            sw_ack_i   = 1'b0;
            quiesced_i = qpat[k];
            if (k == liso - 1) begin
                if (to) drain_m = 1'b1;
                tick_chk("rnd_iso_exit", O_ASRT);
            end else begin
                tick_chk("rnd_iso", O_ISO);
            end
        end
        for (int i = 1; i < max1(hold); i++) begin
            scramble(); rand_ack(); tick_chk("rnd_assert", O_ASRT);
        end
        for (int i = 0; i < max1(settle); i++) begin
            scramble(); rand_ack(); tick_chk("rnd_settle", O_ISO);
        end
        scramble(); rand_ack(); tick_chk("rnd_clear", O_CLR);
        scramble(); rand_ack(); bump_cnt();
        if (ack_en) begin
            tick_chk("rnd_wait_entry", O_ISO);
            wait_n = $urandom_range(0, 3);
            repeat (wait_n) begin
                scramble(); sw_ack_i = 1'b0; tick_chk("rnd_wait", O_ISO);
            end
            scramble(); sw_ack_i = 1'b1; drain_m = 1'b0;
            tick_chk("rnd_ack", O_IDLE);
        end else begin
            tick_chk("rnd_done", O_IDLE);
        end
        rst_req_i = 1'b0; rand_ack();
        tick_chk("rnd_idle", O_IDLE);
        sw_ack_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; rst_req_i = 1'b0; quiesced_i = 1'b0; drain_budget_i = '0;
        hold_cycles_i = '0; settle_cycles_i = '0; sw_ack_en_i = 1'b0; sw_ack_i = 1'b0;
        #17;
        check("reset_values", obs(), {O_IDLE, 8'd0});
        rst_ni = 1'b1;

        // Immediate quiesce, H=4 S=2, then a drain timeout with budget 5 and a later ack.
        tbl[0]  = mk(1, 1, 0, 0, 3, 4, 2, O_ISO, 0);
        tbl[1]  = mk(0, 1, 0, 0, 3, 4, 2, O_ASRT, 0);
        tbl[2]  = mk(0, 1, 0, 0, 3, 4, 2, O_ASRT, 0);
        tbl[3]  = mk(0, 1, 0, 0, 3, 4, 2, O_ASRT, 0);
        tbl[4]  = mk(0, 1, 0, 0, 3, 4, 2, O_ASRT, 0);
        tbl[5]  = mk(0, 1, 0, 0, 3, 4, 2, O_ISO, 0);
        tbl[6]  = mk(0, 1, 0, 0, 3, 4, 2, O_ISO, 0);
        tbl[7]  = mk(0, 1, 0, 0, 3, 4, 2, O_CLR, 0);
        tbl[8]  = mk(0, 1, 0, 0, 3, 4, 2, O_IDLE, 1);
        tbl[9]  = mk(0, 1, 0, 0, 3, 4, 2, O_IDLE, 1);
        tbl[10] = mk(1, 0, 0, 0, 5, 1, 1, O_ISO, 1);
        for (int i = 11; i <= 15; i++) tbl[i] = mk(0, 0, 0, 0, 5, 1, 1, O_ISO, 1);
        tbl[16] = mk(0, 0, 0, 0, 5, 1, 1, O_ASRT | 6'b1, 1);
        tbl[17] = mk(0, 0, 0, 0, 5, 1, 1, O_ISO | 6'b1, 1);
        tbl[18] = mk(0, 0, 0, 0, 5, 1, 1, O_CLR | 6'b1, 1);
        tbl[19] = mk(0, 0, 0, 0, 5, 1, 1, O_IDLE | 6'b1, 2);
        tbl[20] = mk(0, 0, 1, 0, 5, 1, 1, O_IDLE, 2);
        tbl[21] = mk(0, 0, 0, 0, 5, 1, 1, O_IDLE, 2);
        for (int i = 0; i < 22; i++) begin
            rst_req_i = tbl[i].req; quiesced_i = tbl[i].quies; sw_ack_i = tbl[i].ack;
            sw_ack_en_i = tbl[i].ack_en; drain_budget_i = tbl[i].drain;
            hold_cycles_i = tbl[i].hold; settle_cycles_i = tbl[i].settle;
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d", i), obs(), {tbl[i].exp_o, tbl[i].exp_cnt});
        end
        cnt_m = 2; drain_m = 1'b0; sw_ack_i = 1'b0;

        // Software-acknowledge hold for 20 cycles.
        sw_ack_en_i = 1'b1; quiesced_i = 1'b1; hold_cycles_i = 10'd1; settle_cycles_i = 10'd1;
        rst_req_i = 1'b1; tick_chk("ack_iso", O_ISO);
        rst_req_i = 1'b0; tick_chk("ack_assert", O_ASRT);
        tick_chk("ack_settle", O_ISO);
        tick_chk("ack_clear", O_CLR);
        bump_cnt();
        repeat (20) tick_chk("ack_wait", O_ISO);
        sw_ack_i = 1'b1; tick_chk("ack_release", O_IDLE);
        sw_ack_i = 1'b0; sw_ack_en_i = 1'b0; tick_chk("ack_idle", O_IDLE);

        // Zero hold/settle, with a hold change mid-recovery.
        hold_cycles_i = 10'd0; settle_cycles_i = 10'd0;
        rst_req_i = 1'b1; tick_chk("zero_iso", O_ISO);
        rst_req_i = 1'b0; hold_cycles_i = 10'd9; tick_chk("zero_assert", O_ASRT);
        tick_chk("zero_settle", O_ISO);
        tick_chk("zero_clear", O_CLR);
        bump_cnt();
        tick_chk("zero_done", O_IDLE);
        tick_chk("zero_idle", O_IDLE);

        for (int r = 0; r < 25; r++) random_recovery();

        // Held request: back-to-back recoveries until the counter saturates.
        quiesced_i = 1'b1; hold_cycles_i = '0; settle_cycles_i = '0; sw_ack_en_i = 1'b0;
        sw_ack_i = 1'b0; rst_req_i = 1'b1;
        for (int r = 0; r < 300; r++) begin
            tick_chk("held_iso", O_ISO);
            tick_chk("held_assert", O_ASRT);
            tick_chk("held_settle", O_ISO);
            tick_chk("held_clear", O_CLR);
            bump_cnt();
            tick_chk("held_idle", O_IDLE);
        end
        rst_req_i = 1'b0;
        tick_chk("held_stop", O_IDLE);
        check("count_saturated", {6'b0, rst_count_o}, {6'b0, 8'd255});

        // Asynchronous reset in the second ASSERT cycle.
        hold_cycles_i = 10'd4; settle_cycles_i = 10'd2;
        rst_req_i = 1'b1; tick_chk("arst_iso", O_ISO);
        rst_req_i = 1'b0; tick_chk("arst_assert1", O_ASRT);
        tick_chk("arst_assert2", O_ASRT);
        #2;
        rst_ni = 1'b0;
        #1;
        cnt_m = 0; drain_m = 1'b0;
        check("arst_immediate", obs(), {O_IDLE, 8'd0});
        #3;
        rst_ni = 1'b1;
        repeat (3) tick_chk("arst_stay_idle", O_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
